// File: rtl/reg_bank_wr_pkg.sv
// Shared types and sizing for the RV32E register bank write side.
// The state encoding is fixed because the hazard unit decodes pend_valid from it.
package reg_bank_wr_pkg;
   localparam int XLEN = 32;
   localparam int AW   = 4;
   localparam int NREG = 2 ** AW;
   localparam int CW   = 16;

   localparam logic [AW-1:0] REG_ZERO = 4'h0;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_e;
endpackage

// File: rtl/reg_bank_wr_if.sv
// Write-back buses, hold-buffer status and parallel register outputs of the bank.
// master = pipeline / bench side, slave = reg_bank_wr.
interface reg_bank_wr_if;
   import reg_bank_wr_pkg::*;

   logic            ld_valid;
   logic [AW-1:0]   ld_addr;
   logic [XLEN-1:0] ld_data;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            wb_ready;
   logic            pend_valid;
   logic [AW-1:0]   pend_addr;
   logic [CW-1:0]   wr_count;
   logic [XLEN-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
   logic [XLEN-1:0] q8, q9, q10, q11, q12, q13, q14, q15;

   modport master (
      output ld_valid, ld_addr, ld_data, wb_valid, wb_addr, wb_data,
      input  wb_ready, pend_valid, pend_addr, wr_count,
      input  q0, q1, q2, q3, q4, q5, q6, q7,
      input  q8, q9, q10, q11, q12, q13, q14, q15
   );

   modport slave (
      input  ld_valid, ld_addr, ld_data, wb_valid, wb_addr, wb_data,
      output wb_ready, pend_valid, pend_addr, wr_count,
      output q0, q1, q2, q3, q4, q5, q6, q7,
      output q8, q9, q10, q11, q12, q13, q14, q15
   );
endinterface

// File: rtl/reg_wr_decoder.sv
// Register write-enable decoder: address to one-hot, gated by en_i.
// Bit 0 is never set so x0 can never be written.
module reg_wr_decoder
   import reg_bank_wr_pkg::*;
(
   input  logic            en_i,
   input  logic [AW-1:0]   addr_i,
   output logic [NREG-1:0] onehot_o
);
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[addr_i] = 1'b1;
      end
      onehot_o[REG_ZERO] = 1'b0;
   end
endmodule

// File: rtl/reg_bank_wr.sv
// RV32E register bank write side: merges never-stalled loads with ALU write-back,
// parking a colliding ALU result in a 1-entry hold buffer; one regfile write per cycle.
module reg_bank_wr
   import reg_bank_wr_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   reg_bank_wr_if.slave bus
);
   state_e          state_q, state_d;
   logic            wb_ready_q;
   logic [AW-1:0]   hold_addr_q, hold_addr_d;
   logic [XLEN-1:0] hold_data_q, hold_data_d;
   logic [CW-1:0]   wr_count_q, wr_count_d;
   logic [XLEN-1:0] regs_q [1:NREG-1];

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [NREG-1:0] wr_onehot;

   // Loads always win the write port; a held ALU result drains only in a load-free cycle,
   // so for a shared destination the (younger) ALU value lands last.
   always_comb begin
      state_d     = state_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      wr_en       = 1'b0;
      wr_addr     = REG_ZERO;
      wr_data     = '0;
      case (state_q)
         IDLE: begin
            if (bus.ld_valid) begin
               wr_en   = 1'b1;
               wr_addr = bus.ld_addr;
               wr_data = bus.ld_data;
               if (bus.wb_valid) begin
                  hold_addr_d = bus.wb_addr;
                  hold_data_d = bus.wb_data;
                  state_d     = HELD;
               end
            end else if (bus.wb_valid) begin
               wr_en   = 1'b1;
               wr_addr = bus.wb_addr;
               wr_data = bus.wb_data;
            end
         end
         HELD: begin
            wr_en = 1'b1;
            if (bus.ld_valid) begin
               wr_addr = bus.ld_addr;
               wr_data = bus.ld_data;
            end else begin
               wr_addr = hold_addr_q;
               wr_data = hold_data_q;
               state_d = IDLE;
            end
         end
      endcase
      wr_count_d = wr_count_q + CW'(|wr_onehot);
   end

   reg_wr_decoder u_dec (
      .en_i     (wr_en),
      .addr_i   (wr_addr),
      .onehot_o (wr_onehot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wb_ready_q  <= 1'b1;
         hold_addr_q <= REG_ZERO;
         hold_data_q <= '0;
         wr_count_q  <= '0;
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wb_ready_q  <= (state_d == IDLE);
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         wr_count_q  <= wr_count_d;
         for (int i = 1; i < NREG; i++) begin
            if (wr_onehot[i]) begin
               regs_q[i] <= wr_data;
            end
         end
      end
   end

   assign bus.wb_ready   = wb_ready_q;
   assign bus.pend_valid = (state_q == HELD);
   assign bus.pend_addr  = hold_addr_q;
   assign bus.wr_count   = wr_count_q;

   assign bus.q0  = '0;
   assign bus.q1  = regs_q[1];
   assign bus.q2  = regs_q[2];
   assign bus.q3  = regs_q[3];
   assign bus.q4  = regs_q[4];
   assign bus.q5  = regs_q[5];
   assign bus.q6  = regs_q[6];
   assign bus.q7  = regs_q[7];
   assign bus.q8  = regs_q[8];
   assign bus.q9  = regs_q[9];
   assign bus.q10 = regs_q[10];
   assign bus.q11 = regs_q[11];
   assign bus.q12 = regs_q[12];
   assign bus.q13 = regs_q[13];
   assign bus.q14 = regs_q[14];
   assign bus.q15 = regs_q[15];
endmodule

// File: tb/tb_reg_bank_wr.sv
// Bench for reg_bank_wr: directed scenarios plus randomized traffic against a
// queue-based reference model of the register bank.
module tb_reg_bank_wr;
   import reg_bank_wr_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_bank_wr_if bus ();

   reg_bank_wr dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] dq [16];
   assign dq[0]  = bus.q0;
   assign dq[1]  = bus.q1;
   assign dq[2]  = bus.q2;
   assign dq[3]  = bus.q3;
   assign dq[4]  = bus.q4;
   assign dq[5]  = bus.q5;
   assign dq[6]  = bus.q6;
   assign dq[7]  = bus.q7;
   assign dq[8]  = bus.q8;
   assign dq[9]  = bus.q9;
   assign dq[10] = bus.q10;
   assign dq[11] = bus.q11;
   assign dq[12] = bus.q12;
   assign dq[13] = bus.q13;
   assign dq[14] = bus.q14;
   assign dq[15] = bus.q15;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
   } wr_t;

   // Reference: architectural register array, write counter, and a queue of ALU
   // results waiting behind loads (at most one may wait).
   logic [31:0] m_reg [16];
   logic [15:0] m_cnt;
   wr_t         m_hold [$];

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_cnt = '0;
      m_hold.delete();
   endfunction

   function automatic void m_write(input wr_t w);
      if (w.a != 4'd0) begin
         m_reg[w.a] = w.d;
         m_cnt      = m_cnt + 16'd1;
      end
   endfunction

   function automatic void model_step();
      wr_t l, w;
      l = {bus.ld_addr, bus.ld_data};
      w = {bus.wb_addr, bus.wb_data};
      if (rst) begin
         m_reset();
         return;
      end
      if (m_hold.size() != 0) begin
         if (bus.ld_valid) m_write(l);
         else              m_write(m_hold.pop_front());
      end else begin
         if (bus.ld_valid) m_write(l);
         if (bus.wb_valid) begin
            if (bus.ld_valid) m_hold.push_back(w);
            else              m_write(w);
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic lv, input logic [3:0] la, input logic [31:0] ld,
                        input logic wv, input logic [3:0] wa, input logic [31:0] wd);
      bus.ld_valid = lv;
      bus.ld_addr  = la;
      bus.ld_data  = ld;
      bus.wb_valid = wv;
      bus.wb_addr  = wa;
      bus.wb_data  = wd;
   endtask

   task automatic drive_idle();
      drive(1'b0, 4'($urandom), $urandom, 1'b0, 4'($urandom), $urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive(1'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom), $urandom);
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (dq[i] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_q%0d: got %h want %h", i, dq[i], 32'h0);
         end
      end
      n_checks++;
      if (bus.wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b want 1", bus.wb_ready); end
      n_checks++;
      if (bus.pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend_valid: got %b want 0", bus.pend_valid); end
      n_checks++;
      if (bus.pend_addr !== 4'h0) begin n_fail++; $display("FAIL reset_pend_addr: got %h want 0", bus.pend_addr); end
      n_checks++;
      if (bus.wr_count !== 16'h0) begin n_fail++; $display("FAIL reset_wr_count: got %h want 0", bus.wr_count); end
      rst = 1'b0;
      drive_idle();
   endtask

   task automatic test_single_alu();
      drive(1'b0, 4'($urandom), $urandom, 1'b1, 4'd5, 32'hDEADBEEF);
      tick();
      drive_idle();
      n_checks++;
      if (dq[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_q5: got %h want DEADBEEF", dq[5]); end
      n_checks++;
      if (bus.wr_count !== 16'd1) begin n_fail++; $display("FAIL alu_wr_count: got %0d want 1", bus.wr_count); end
      n_checks++;
      if (bus.wb_ready !== 1'b1) begin n_fail++; $display("FAIL alu_wb_ready: got %b want 1", bus.wb_ready); end
   endtask

   task automatic test_x0();
      drive(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'($urandom), $urandom);
      tick();
      n_checks++;
      if (dq[0] !== 32'h0) begin n_fail++; $display("FAIL x0_ld_q0: got %h want 0", dq[0]); end
      n_checks++;
      if (bus.wr_count !== 16'd1) begin n_fail++; $display("FAIL x0_ld_wr_count: got %0d want 1", bus.wr_count); end
      drive(1'b0, 4'($urandom), $urandom, 1'b1, 4'd0, 32'h12345678);
      tick();
      drive_idle();
      n_checks++;
      if (dq[0] !== 32'h0) begin n_fail++; $display("FAIL x0_wb_q0: got %h want 0", dq[0]); end
      n_checks++;
      if (bus.wr_count !== 16'd1) begin n_fail++; $display("FAIL x0_wb_wr_count: got %0d want 1", bus.wr_count); end
      n_checks++;
      if (bus.wb_ready !== 1'b1) begin n_fail++; $display("FAIL x0_wb_ready: got %b want 1", bus.wb_ready); end
   endtask

   task automatic test_collision();
      drive(1'b1, 4'd3, 32'h11111111, 1'b1, 4'd3, 32'h22222222);
      tick();
      drive_idle();
      n_checks++;
      if (dq[3] !== 32'h11111111) begin n_fail++; $display("FAIL coll_q3_ld: got %h want 11111111", dq[3]); end
      n_checks++;
      if (bus.pend_valid !== 1'b1) begin n_fail++; $display("FAIL coll_pend_valid: got %b want 1", bus.pend_valid); end
      n_checks++;
      if (bus.pend_addr !== 4'd3) begin n_fail++; $display("FAIL coll_pend_addr: got %h want 3", bus.pend_addr); end
      n_checks++;
      if (bus.wb_ready !== 1'b0) begin n_fail++; $display("FAIL coll_wb_ready: got %b want 0", bus.wb_ready); end
      tick();
      n_checks++;
      if (dq[3] !== 32'h22222222) begin n_fail++; $display("FAIL coll_q3_alu: got %h want 22222222", dq[3]); end
      n_checks++;
      if (bus.wb_ready !== 1'b1 || bus.pend_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_back_idle: got ready=%b pend=%b want ready=1 pend=0", bus.wb_ready, bus.pend_valid);
      end
      n_checks++;
      if (bus.wr_count !== 16'd3) begin n_fail++; $display("FAIL coll_wr_count: got %0d want 3", bus.wr_count); end
   endtask

   task automatic test_ld_stream();
      logic [3:0]  addrs [3];
      logic [31:0] ldd;
      addrs[0] = 4'd1; addrs[1] = 4'd2; addrs[2] = 4'd7;
      drive(1'b1, 4'd9, 32'h99999999, 1'b1, 4'd7, 32'hA5A5A5A5);
      tick();
      ldd = 32'h0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (bus.wb_ready !== 1'b0) begin n_fail++; $display("FAIL stream_wb_ready_%0d: got %b want 0", k, bus.wb_ready); end
         ldd = $urandom;
         // wb_valid kept high with different data: must be ignored while held
         drive(1'b1, addrs[k], ldd, 1'b1, 4'd7, 32'h5A5A5A5A);
         tick();
      end
      drive_idle();
      n_checks++;
      if (dq[7] !== ldd || bus.pend_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stream_q7_ld: got %h pend=%b want %h pend=1", dq[7], bus.pend_valid, ldd);
      end
      tick();
      n_checks++;
      if (dq[7] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL stream_q7_final: got %h want A5A5A5A5", dq[7]); end
      n_checks++;
      if (bus.wb_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_after: got %b want 1", bus.wb_ready); end
      n_checks++;
      if (bus.wr_count !== 16'd8) begin n_fail++; $display("FAIL stream_wr_count: got %0d want 8", bus.wr_count); end
   endtask

   task automatic test_reset_held();
      rst = 1'b1;
      drive_idle();
      tick();
      rst = 1'b0;
      drive(1'b1, 4'd6, 32'h66666666, 1'b1, 4'd4, 32'hCAFEF00D);
      tick();
      n_checks++;
      if (bus.pend_valid !== 1'b1 || bus.pend_addr !== 4'd4) begin
         n_fail++;
         $display("FAIL rheld_setup: got pend=%b addr=%h want pend=1 addr=4", bus.pend_valid, bus.pend_addr);
      end
      rst = 1'b1;
      drive(1'b1, 4'd9, 32'h99999999, 1'b1, 4'd10, 32'hABCDABCD);
      tick();
      n_checks++;
      if (bus.pend_valid !== 1'b0 || bus.wb_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rheld_status: got pend=%b ready=%b want pend=0 ready=1", bus.pend_valid, bus.wb_ready);
      end
      n_checks++;
      if (dq[6] !== 32'h0 || dq[9] !== 32'h0) begin
         n_fail++;
         $display("FAIL rheld_cleared: got q6=%h q9=%h want 0", dq[6], dq[9]);
      end
      rst = 1'b0;
      drive_idle();
      tick();
      tick();
      n_checks++;
      if (dq[4] !== 32'h0) begin n_fail++; $display("FAIL rheld_no_hold_write: got q4=%h want 0", dq[4]); end
      n_checks++;
      if (bus.wr_count !== 16'd0) begin n_fail++; $display("FAIL rheld_wr_count: got %0d want 0", bus.wr_count); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         drive(($urandom_range(0, 2) != 0), 4'($urandom), $urandom,
               ($urandom_range(0, 1) != 0), 4'($urandom), $urandom);
         tick();
         for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dq[i] !== m_reg[i]) begin
               n_fail++;
               $display("FAIL rand_q%0d cyc %0d: got %h want %h", i, c, dq[i], m_reg[i]);
            end
         end
         n_checks++;
         if (bus.wb_ready !== (m_hold.size() == 0)) begin
            n_fail++;
            $display("FAIL rand_wb_ready cyc %0d: got %b want %b", c, bus.wb_ready, m_hold.size() == 0);
         end
         n_checks++;
         if (bus.pend_valid !== (m_hold.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_pend_valid cyc %0d: got %b want %b", c, bus.pend_valid, m_hold.size() != 0);
         end
         if (m_hold.size() != 0) begin
            n_checks++;
            if (bus.pend_addr !== m_hold[0].a) begin
               n_fail++;
               $display("FAIL rand_pend_addr cyc %0d: got %h want %h", c, bus.pend_addr, m_hold[0].a);
            end
         end
         n_checks++;
         if (bus.wr_count !== m_cnt) begin
            n_fail++;
            $display("FAIL rand_wr_count cyc %0d: got %h want %h", c, bus.wr_count, m_cnt);
         end
      end
      rst = 1'b0;
      drive_idle();
      tick();
      tick();
   endtask

   task automatic test_wrap();
      rst = 1'b1;
      drive_idle();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 65535; c++) begin
         drive(1'b1, 4'($urandom_range(1, 15)), $urandom, 1'b0, 4'($urandom), $urandom);
         tick();
      end
      n_checks++;
      if (bus.wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h want FFFF", bus.wr_count); end
      drive(1'b1, 4'd11, 32'h0BADC0DE, 1'b0, 4'($urandom), $urandom);
      tick();
      drive_idle();
      n_checks++;
      if (bus.wr_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", bus.wr_count); end
      n_checks++;
      if (dq[11] !== 32'h0BADC0DE) begin n_fail++; $display("FAIL wrap_q11: got %h want 0BADC0DE", dq[11]); end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (dq[i] !== m_reg[i]) begin
            n_fail++;
            $display("FAIL wrap_model_q%0d: got %h want %h", i, dq[i], m_reg[i]);
         end
      end
   endtask

   initial begin
      m_reset();
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_single_alu();
      test_x0();
      test_collision();
      test_ld_stream();
      test_reset_held();
      test_random();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
